// File: rtl/fwd_pkg.sv
// Shared types and defaults for the forwarding scoreboard.
// Optional build macro used by the scoreboard files: FWD_STATS_EN.
package fwd_pkg;

  localparam int unsigned NUM_SRC_DEF = 2;
  localparam int unsigned DEPTH_DEF   = 3;
  localparam int unsigned MAX_LAT_DEF = 4;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  // Entry fields are sized for DEPTH and MAX_LAT up to 15.
  localparam int unsigned SB_AGE_W = 4;
  localparam int unsigned SB_LAT_W = 4;

  // Full-range forwarding select; the top narrows it to the port width.
  typedef logic [SB_AGE_W-1:0] fwd_sel_t;

  typedef struct packed {
    logic                busy;
    logic [SB_AGE_W-1:0] age;
    logic [SB_LAT_W-1:0] rdy_cnt;
  } sb_entry_t;

  // A producer still inside the pipeline forwards from its stage register;
  // once it reaches the last stage the regfile already holds the value.
  function automatic fwd_sel_t fwd_sel_of(input sb_entry_t e, input int unsigned depth);
    return (e.busy && (e.age < SB_AGE_W'(depth))) ? e.age : '0;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue/forwarding bus between the ID stage (master) and the scoreboard (slave).
// FWD_STATS_EN adds the statistics counters to the bus.
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF
);
  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
  localparam int unsigned SEL_W = $clog2(DEPTH);

  logic                            i_issue_vld;
  logic                            i_issue_rd_wren;
  logic [REG_W-1:0]                i_issue_rd_addr;
  logic [LAT_W-1:0]                i_issue_lat;
  logic [NUM_SRC-1:0][REG_W-1:0]   i_issue_rs_addr;
  logic                            i_flush;
  logic                            i_hold;
  logic                            o_stall;
  logic [NUM_SRC-1:0][SEL_W-1:0]   o_ex_fwd_sel;
  logic                            o_ex_bubble;
`ifdef FWD_STATS_EN
  logic [31:0]                     o_stall_cnt;
  logic [31:0]                     o_fwd_cnt;

  modport master (
    output i_issue_vld, i_issue_rd_wren, i_issue_rd_addr, i_issue_lat,
           i_issue_rs_addr, i_flush, i_hold,
    input  o_stall, o_ex_fwd_sel, o_ex_bubble, o_stall_cnt, o_fwd_cnt
  );
  modport slave (
    input  i_issue_vld, i_issue_rd_wren, i_issue_rd_addr, i_issue_lat,
           i_issue_rs_addr, i_flush, i_hold,
    output o_stall, o_ex_fwd_sel, o_ex_bubble, o_stall_cnt, o_fwd_cnt
  );
`else
  modport master (
    output i_issue_vld, i_issue_rd_wren, i_issue_rd_addr, i_issue_lat,
           i_issue_rs_addr, i_flush, i_hold,
    input  o_stall, o_ex_fwd_sel, o_ex_bubble
  );
  modport slave (
    input  i_issue_vld, i_issue_rd_wren, i_issue_rd_addr, i_issue_lat,
           i_issue_rs_addr, i_flush, i_hold,
    output o_stall, o_ex_fwd_sel, o_ex_bubble
  );
`endif

endinterface

// File: rtl/fwd_sb_entry.sv
// One scoreboard entry: tracks an in-flight producer of a single register.
module fwd_sb_entry
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_hold,
  input  logic                i_set,
  input  logic [SB_LAT_W-1:0] i_lat,
  output sb_entry_t           o_entry
);

  sb_entry_t r_entry;

  // Set on a new producer, otherwise age the entry and retire it after the last stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_entry <= '0;
    end else if (!i_hold) begin
      if (i_set) begin
        r_entry.busy    <= 1'b1;
        r_entry.age     <= SB_AGE_W'(1);
        r_entry.rdy_cnt <= i_lat;
      end else if (r_entry.busy) begin
        if (r_entry.age >= SB_AGE_W'(DEPTH)) begin
          r_entry <= '0;
        end else begin
          r_entry.age     <= r_entry.age + 1'b1;
          r_entry.rdy_cnt <= (r_entry.rdy_cnt == '0) ? '0 : r_entry.rdy_cnt - 1'b1;
        end
      end
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: stalls ID on unready operands and registers EX bypass selects.
// Define FWD_STATS_EN to add the o_stall_cnt / o_fwd_cnt statistics counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  fwd_scoreboard_if.slave        io_bus
);

  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
  localparam int unsigned SEL_W = $clog2(DEPTH);

  sb_entry_t                     w_ent [NUM_REGS];
  logic                          w_accept;
  logic                          w_stall;
  logic [LAT_W-1:0]              w_lat;
  logic [NUM_SRC-1:0][SEL_W-1:0] w_sel;
  logic [NUM_SRC-1:0][SEL_W-1:0] r_fwd_sel;
  logic                          r_bubble;

  assign w_lat    = io_bus.i_issue_lat;
  assign w_accept = io_bus.i_issue_vld & ~w_stall & ~io_bus.i_flush & ~io_bus.i_hold;

  // x0 never has a producer, so its entry is a constant idle slot.
  assign w_ent[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_ent
    fwd_sb_entry #(.DEPTH(DEPTH)) u_entry (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_hold  (io_bus.i_hold),
      .i_set   (w_accept && io_bus.i_issue_rd_wren &&
                (io_bus.i_issue_rd_addr == REG_W'(g))),
      .i_lat   (SB_LAT_W'(w_lat)),
      .o_entry (w_ent[g])
    );
  end

  // Hazard check and select computation against the pre-update table.
  always_comb begin
    w_stall = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (io_bus.i_issue_rs_addr[k] != '0) begin
        if (w_ent[io_bus.i_issue_rs_addr[k]].busy &&
            (w_ent[io_bus.i_issue_rs_addr[k]].rdy_cnt > SB_LAT_W'(1)))
          w_stall = 1'b1;
        w_sel[k] = SEL_W'(fwd_sel_of(w_ent[io_bus.i_issue_rs_addr[k]], DEPTH));
      end
    end
    w_stall = w_stall & io_bus.i_issue_vld;
  end

  // EX-stage select/bubble register; frozen by hold, reset wins over hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fwd_sel <= '0;
      r_bubble  <= 1'b1;
    end else if (!io_bus.i_hold) begin
      if (w_accept) begin
        r_fwd_sel <= w_sel;
        r_bubble  <= 1'b0;
      end else begin
        r_fwd_sel <= '0;
        r_bubble  <= 1'b1;
      end
    end
  end

  assign io_bus.o_stall      = w_stall;
  assign io_bus.o_ex_fwd_sel = r_fwd_sel;
  assign io_bus.o_ex_bubble  = r_bubble;

`ifdef FWD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  // Stall cycles are counted even under hold since o_stall is still live then.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_accept && (w_sel != '0))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign io_bus.o_stall_cnt = r_stall_cnt;
  assign io_bus.o_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning source operands checked per issued instruction.
REQ-002 SHALL have parameter DEPTH, default 3, meaning pipeline stages from EX to WB inclusive, with regfile write at end of stage DEPTH.
REQ-003 SHALL have parameter MAX_LAT, default 4, meaning maximum producer latency in cycles.
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_issue_vld  in  1  ID instruction requests entry to EX.
REQ-007 SHALL have port i_issue_rd_wren / i_issue_rd_addr  in  1 / 5  producer destination.
REQ-008 SHALL have port i_issue_lat  in  $clog2(MAX_LAT+1)  cycles after EX entry until result sits in a forwardable pipeline register (ALU=1, load=2).
REQ-009 SHALL have port i_issue_rs_addr  in  NUM_SRC x 5  ID source addresses.
REQ-010 SHALL have port i_flush  in  1  suppress this cycle's issue.
REQ-011 SHALL have port i_hold  in  1  global pipeline freeze.
REQ-012 SHALL have port o_stall  out  1  combinational, ID must not advance.
REQ-013 SHALL have port o_ex_fwd_sel  out  NUM_SRC x $clog2(DEPTH)  registered per-source select for EX: 0=regfile, k=output register of stage k (1=EX/MEM, 2=MEM/WB).
REQ-014 SHALL have port o_ex_bubble  out  1  registered, EX holds a bubble.

Function
REQ-015 SHALL keep per architectural register r (1..31): busy, age (1..DEPTH), rdy_cnt (0..MAX_LAT).
REQ-016 SHALL accept an issue when i_issue_vld & ~o_stall & ~i_flush & ~i_hold.
REQ-017 SHALL, on accepted issue with wren and rd!=0, set entry rd to busy=1, age=1, rdy_cnt=i_issue_lat, overriding any older entry for rd (youngest wins).
REQ-018 SHALL, every non-hold cycle, for each other busy entry: age+1, rdy_cnt decrement saturating at 0; age==DEPTH clears busy.
REQ-019 SHALL assert o_stall when i_issue_vld and any source k has rs!=0, busy[rs], and rdy_cnt[rs]>1.
REQ-020 SHALL evaluate hazards against pre-update state; an instruction's own rd never matches its own sources.
REQ-021 SHALL, on accepted issue, register o_ex_fwd_sel[k] = busy[rs_k] & age<DEPTH ? age : 0, and o_ex_bubble=0.
REQ-022 SHALL, on a non-hold cycle without accepted issue, register o_ex_fwd_sel=0 and o_ex_bubble=1.
REQ-023 SHALL, on i_hold, freeze all entries and registered outputs; o_stall still evaluated.
REQ-024 SHALL ignore rd=0 producers and rs=0 sources (never stall, select 0).
REQ-025 SHALL give i_reset priority over i_hold, i_hold over i_flush.

Reset
REQ-026 SHALL on i_reset clear all busy/age/rdy_cnt, o_ex_fwd_sel=0, o_ex_bubble=1, in the same edge, including mid-stall.

Configuration
REQ-027 SHALL, with FWD_STATS_EN defined, add o_stall_cnt and o_fwd_cnt (32-bit, wrap, reset 0) counting o_stall cycles and accepted issues with any nonzero select; without it those ports and counters SHALL not exist.

Structure
REQ-028 SHALL import package fwd_pkg holding DEPTH/MAX_LAT defaults, fwd_sel_t and sb_entry_t (busy, age, rdy_cnt).
REQ-029 SHALL instantiate sub-module fwd_sb_entry per register (set, advance, hold, retire).

Verification
REQ-030 SHALL cover ALU back-to-back: add x5 (lat1) then add x6,x5 -> no stall, o_ex_fwd_sel[0]=1.
REQ-031 SHALL cover load-use: lw x5 (lat2) then add x7,x5 -> o_stall one cycle, o_ex_bubble=1, then sel=2.
REQ-032 SHALL cover distance 3: producer x5 then two unrelated then consumer -> sel=0 (regfile).
REQ-033 SHALL cover WAW: lw x5 then addi x5 then use x5 -> sel=1 from younger, no stall.
REQ-034 SHALL cover i_hold two cycles during load-use stall -> entries/outputs frozen, one-bubble total after release.
REQ-035 SHALL cover i_reset asserted while x5 busy -> next cycle use of x5 gives no stall, sel=0.
